// File: rtl/tft_pkg.sv
// Shared types and constants for the TFT pixel streamer: FSM state encoding,
// pixel width and the default panel geometry.
package tft_pkg;

  localparam int RGB565_WIDTH         = 16;
  localparam int PANEL_WIDTH          = 320;
  localparam int PANEL_HEIGHT         = 240;
  localparam int FRAME_PIXELS_DEFAULT = PANEL_WIDTH * PANEL_HEIGHT;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LOAD  = 3'd2,
    ST_SHIFT = 3'd3,
    ST_STOP  = 3'd4
  } tft_state_e;

endpackage

// File: rtl/tft_pixel_streamer_if.sv
// FIFO read port plus TFT panel pins, grouped so the streamer and its bench
// share one bundle.
interface tft_pixel_streamer_if
  import tft_pkg::*;
#(
  parameter int DATA_WIDTH = RGB565_WIDTH
) ();

  // FIFO read: the reader raises fifo_rd_en for one cycle only while
  // fifo_empty=0; fifo_data is valid the cycle after that strobe.
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  fifo_rd_en;

  logic tft_cs_n;
  logic tft_sclk;
  logic tft_mosi;
  logic tft_dc;

  modport master (
    input  fifo_empty,
    input  fifo_data,
    output fifo_rd_en,
    output tft_cs_n,
    output tft_sclk,
    output tft_mosi,
    output tft_dc
  );

  modport slave (
    output fifo_empty,
    output fifo_data,
    input  fifo_rd_en,
    input  tft_cs_n,
    input  tft_sclk,
    input  tft_mosi,
    input  tft_dc
  );

endinterface

// File: rtl/tft_spi_shifter.sv
// SPI mode-0 serialiser: shifts one word MSB-first, CLK_DIV clocks per SCLK
// half-period, and flags the cycle before the final falling SCLK edge.
module tft_spi_shifter
  import tft_pkg::*;
#(
  parameter int DATA_WIDTH = RGB565_WIDTH,
  parameter int CLK_DIV    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  clear_i,
  output logic                  sclk_o,
  output logic                  mosi_o,
  output logic                  done_o
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(DATA_WIDTH);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic                  sclk_q, sclk_d;
  logic                  active_q, active_d;
  logic                  phase_end;

  assign phase_end = (div_q == DIV_LAST);
  assign done_o    = active_q && phase_end && sclk_q && (bit_q == BIT_LAST);
  assign sclk_o    = sclk_q;
  // MOSI is the register MSB, so it can only move when the word shifts.
  assign mosi_o    = shreg_q[DATA_WIDTH-1];

  always_comb begin
    shreg_d  = shreg_q;
    div_d    = div_q;
    bit_d    = bit_q;
    sclk_d   = sclk_q;
    active_d = active_q;
    if (load_i) begin
      shreg_d  = data_i;
      div_d    = '0;
      bit_d    = '0;
      sclk_d   = 1'b0;
      active_d = 1'b1;
    end else if (clear_i) begin
      shreg_d = '0;
    end else if (active_q) begin
      if (!phase_end) begin
        div_d = div_q + 1'b1;
      end else begin
        div_d = '0;
        if (!sclk_q) begin
          sclk_d = 1'b1;
        end else begin
          sclk_d = 1'b0;
          if (bit_q == BIT_LAST) begin
            active_d = 1'b0;
          end else begin
            bit_d   = bit_q + 1'b1;
            shreg_d = {shreg_q[DATA_WIDTH-2:0], 1'b0};
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q  <= '0;
      div_q    <= '0;
      bit_q    <= '0;
      sclk_q   <= 1'b0;
      active_q <= 1'b0;
    end else begin
      shreg_q  <= shreg_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      sclk_q   <= sclk_d;
      active_q <= active_d;
    end
  end

endmodule

// File: rtl/tft_pixel_streamer.sv
// Drains RGB565 pixels from the FIFO, streams them to the TFT over SPI and
// tracks the position within the current frame.
module tft_pixel_streamer
  import tft_pkg::*;
#(
  parameter int DATA_WIDTH   = RGB565_WIDTH,
  parameter int CLK_DIV      = 2,
  parameter int FRAME_PIXELS = FRAME_PIXELS_DEFAULT
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            enable,
  tft_pixel_streamer_if.master            bus,
  output logic                            busy,
  output logic [$clog2(FRAME_PIXELS)-1:0] pixel_count,
  output logic                            frame_done,
  output tft_state_e                      dbg_state
);

  localparam int PCW = $clog2(FRAME_PIXELS);
  localparam logic [PCW-1:0] PIX_LAST = PCW'(FRAME_PIXELS - 1);

  tft_state_e     state_q, state_d;
  logic           rd_en_q, rd_en_d;
  logic           cs_n_q, cs_n_d;
  logic           dc_q, dc_d;
  logic           busy_q, busy_d;
  logic [PCW-1:0] pix_q, pix_d;
  logic           fd_q, fd_d;
  logic           shift_done;
  logic           sclk, mosi;

  tft_spi_shifter #(
    .DATA_WIDTH (DATA_WIDTH),
    .CLK_DIV    (CLK_DIV)
  ) u_shifter (
    .clk     (clk),
    .rst_n   (reset_n),
    .load_i  (state_q == ST_LOAD),
    .data_i  (bus.fifo_data),
    .clear_i (state_q == ST_STOP),
    .sclk_o  (sclk),
    .mosi_o  (mosi),
    .done_o  (shift_done)
  );

  always_comb begin
    state_d = state_q;
    cs_n_d  = cs_n_q;
    dc_d    = dc_q;
    pix_d   = pix_q;
    fd_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable && !bus.fifo_empty) state_d = ST_FETCH;
      end
      ST_FETCH: state_d = ST_LOAD;
      ST_LOAD: begin
        state_d = ST_SHIFT;
        cs_n_d  = 1'b0;
        dc_d    = 1'b1;
      end
      ST_SHIFT: begin
        if (shift_done) begin
          if (pix_q == PIX_LAST) begin
            pix_d = '0;
            fd_d  = 1'b1;
          end else begin
            pix_d = pix_q + 1'b1;
          end
          // Staying in FETCH keeps cs_n low for back-to-back pixels.
          if (enable && !bus.fifo_empty) state_d = ST_FETCH;
          else                           state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        state_d = ST_IDLE;
        cs_n_d  = 1'b1;
        dc_d    = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
    rd_en_d = (state_d == ST_FETCH);
    busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      rd_en_q <= 1'b0;
      cs_n_q  <= 1'b1;
      dc_q    <= 1'b0;
      busy_q  <= 1'b0;
      pix_q   <= '0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_en_q <= rd_en_d;
      cs_n_q  <= cs_n_d;
      dc_q    <= dc_d;
      busy_q  <= busy_d;
      pix_q   <= pix_d;
      fd_q    <= fd_d;
    end
  end

  assign bus.fifo_rd_en = rd_en_q;
  assign bus.tft_cs_n   = cs_n_q;
  assign bus.tft_sclk   = sclk;
  assign bus.tft_mosi   = mosi;
  assign bus.tft_dc     = dc_q;
  assign busy           = busy_q;
  assign pixel_count    = pix_q;
  assign frame_done     = fd_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_tft_pixel_streamer.sv
// Bench for tft_pixel_streamer: FIFO model, SPI receiver with scoreboard,
// and directed plus randomized pixel traffic.
module tb_tft_pixel_streamer;
  import tft_pkg::*;

  localparam int CLK_DIV = 2;
  localparam int FP      = 4;
  localparam int DW      = 16;
  localparam int PIX_CYC = 32 * CLK_DIV + 2;
  localparam int LIMIT   = 5000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic enable = 1'b0;
  always #5 clk = ~clk;

  logic                  busy;
  logic                  frame_done;
  logic [$clog2(FP)-1:0] pixel_count;
  tft_state_e            dbg_state;

  tft_pixel_streamer_if #(.DATA_WIDTH(DW)) bus ();

  tft_pixel_streamer #(
    .DATA_WIDTH   (DW),
    .CLK_DIV      (CLK_DIV),
    .FRAME_PIXELS (FP)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .bus         (bus.master),
    .busy        (busy),
    .pixel_count (pixel_count),
    .frame_done  (frame_done),
    .dbg_state   (dbg_state)
  );

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- FIFO model + SPI receiver + scoreboard ----------------
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  int            rd_times[$];
  int            rise_times[$];
  int            cyc = 0;
  int            rd_cnt = 0;
  int            cs_rise_cnt = 0;
  int            fd_cnt = 0;
  int            bit_idx = 0;
  logic [DW-1:0] rx_word = '0;
  logic [DW-1:0] last_word = '0;
  logic [DW-1:0] pend_val = '0;
  logic          pend = 1'b0;
  logic          prev_sclk = 1'b0;
  logic          prev_mosi = 1'b0;
  logic          prev_cs = 1'b1;
  logic          prev_rd = 1'b0;

  always @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_idx   = 0;
      rx_word   = '0;
      pend      = 1'b0;
      prev_sclk = 1'b0;
      prev_mosi = 1'b0;
      prev_cs   = 1'b1;
      prev_rd   = 1'b0;
      fd_cnt    = 0;
      bus.fifo_empty = (fifo_q.size() == 0);
    end else begin
      cyc++;
      // Popped word appears on fifo_data one cycle after the strobe.
      if (pend) begin
        bus.fifo_data = pend_val;
        pend = 1'b0;
      end
      if (bus.fifo_rd_en) begin
        check_eq("rd_en_nonempty", fifo_q.size() != 0, 1);
        check_eq("rd_en_single", prev_rd, 0);
        rd_cnt++;
        rd_times.push_back(cyc);
        if (fifo_q.size() != 0) begin
          pend_val = fifo_q.pop_front();
          pend = 1'b1;
          exp_q.push_back(pend_val);
        end
      end
      if (bus.tft_sclk) check_eq("mosi_stable_high", bus.tft_mosi, prev_mosi);
      if (bus.tft_sclk && !prev_sclk) begin
        check_eq("cs_n_at_sclk", bus.tft_cs_n, 0);
        check_eq("dc_at_sclk", bus.tft_dc, 1);
        rise_times.push_back(cyc);
        rx_word = {rx_word[DW-2:0], bus.tft_mosi};
        bit_idx++;
        if (bit_idx == DW) begin
          bit_idx   = 0;
          last_word = rx_word;
          check_eq("pixel_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) check_eq("pixel_data", rx_word, exp_q.pop_front());
        end
      end
      if (bus.tft_cs_n && !prev_cs) cs_rise_cnt++;
      if (frame_done) begin
        fd_cnt++;
        check_eq("pixcnt_at_frame_done", pixel_count, 0);
      end
      prev_sclk = bus.tft_sclk;
      prev_mosi = bus.tft_mosi;
      prev_cs   = bus.tft_cs_n;
      prev_rd   = bus.fifo_rd_en;
      bus.fifo_empty = (fifo_q.size() == 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_pixel(input logic [DW-1:0] v);
    fifo_q.push_back(v);
  endtask

  task automatic wait_idle(input string tag);
    int  n;
    logic done;
    done = 1'b0;
    for (n = 0; n < LIMIT && !done; n++) begin
      @(negedge clk);
      #1;
      done = !busy && (fifo_q.size() == 0 || !enable);
    end
    check_eq(tag, done, 1);
  endtask

  task automatic wait_bits(input int k, input string tag);
    int  n;
    logic done;
    done = 1'b0;
    for (n = 0; n < LIMIT && !done; n++) begin
      @(negedge clk);
      #1;
      done = (bit_idx >= k);
    end
    check_eq(tag, done, 1);
  endtask

  task automatic clear_logs();
    rd_times.delete();
    rise_times.delete();
    rd_cnt      = 0;
    cs_rise_cnt = 0;
  endtask

  // ---------------- stimulus ----------------
  int sent = 0;

  initial begin
    // Reset values, then idle with an empty FIFO.
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_rd_en", bus.fifo_rd_en, 0);
    check_eq("rst_cs_n", bus.tft_cs_n, 1);
    check_eq("rst_sclk", bus.tft_sclk, 0);
    check_eq("rst_mosi", bus.tft_mosi, 0);
    check_eq("rst_dc", bus.tft_dc, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_pixcnt", pixel_count, 0);
    check_eq("rst_frame_done", frame_done, 0);
    check_eq("rst_state", dbg_state, ST_IDLE);
    enable  = 1'b1;
    reset_n = 1'b1;
    clear_logs();
    repeat (20) @(negedge clk);
    #1;
    check_eq("empty_no_rd", rd_cnt, 0);
    check_eq("empty_busy", busy, 0);
    check_eq("empty_cs_n", bus.tft_cs_n, 1);

    // Single pixel with latency and bit-timing checks.
    clear_logs();
    push_pixel(16'hA5C3);
    wait_idle("single_timeout");
    sent++;
    check_eq("single_rd_cnt", rd_cnt, 1);
    check_eq("single_rises", rise_times.size(), 16);
    if (rise_times.size() >= 16 && rd_times.size() >= 1) begin
      check_eq("first_rise_latency", rise_times[0] - rd_times[0], 2 + CLK_DIV);
      check_eq("bit_period_span", rise_times[15] - rise_times[0], 15 * 2 * CLK_DIV);
    end
    check_eq("single_word", last_word, 16'hA5C3);
    check_eq("single_pixcnt", pixel_count, 1);
    check_eq("single_cs_n_end", bus.tft_cs_n, 1);
    check_eq("single_dc_end", bus.tft_dc, 0);
    check_eq("single_mosi_end", bus.tft_mosi, 0);
    check_eq("single_state_end", dbg_state, ST_IDLE);

    // Four pixels back-to-back: one cs_n rise, fetches one pixel-time apart.
    clear_logs();
    for (int i = 0; i < 4; i++) push_pixel(DW'($urandom_range(0, 16'hFFFF)));
    wait_idle("burst_timeout");
    sent += 4;
    check_eq("burst_rd_cnt", rd_cnt, 4);
    for (int i = 1; i < rd_times.size(); i++)
      check_eq("burst_rd_gap", rd_times[i] - rd_times[i-1], PIX_CYC);
    check_eq("burst_cs_rises", cs_rise_cnt, 1);
    check_eq("burst_pixcnt", pixel_count, sent % FP);
    check_eq("burst_frame_done", fd_cnt, sent / FP);

    // Enable dropped mid-pixel: pixel finishes, nothing more is fetched.
    clear_logs();
    push_pixel(16'h1234);
    push_pixel(16'hBEEF);
    wait_bits(5, "en_drop_bits_timeout");
    enable = 1'b0;
    wait_idle("en_drop_timeout");
    sent++;
    check_eq("en_drop_rd_cnt", rd_cnt, 1);
    check_eq("en_drop_word", last_word, 16'h1234);
    check_eq("en_drop_fifo_left", fifo_q.size(), 1);
    check_eq("en_drop_state", dbg_state, ST_IDLE);
    check_eq("en_drop_cs_n", bus.tft_cs_n, 1);
    enable = 1'b1;
    wait_idle("en_resume_timeout");
    sent++;
    check_eq("en_resume_word", last_word, 16'hBEEF);
    check_eq("en_resume_pixcnt", pixel_count, sent % FP);

    // Randomized traffic with enable toggling.
    for (int i = 0; i < 20; i++) begin
      push_pixel(DW'($urandom_range(0, 16'hFFFF)));
      sent++;
      enable = ($urandom_range(0, 3) != 0);
      repeat ($urandom_range(0, 90)) @(negedge clk);
      #1;
    end
    enable = 1'b1;
    wait_idle("rand_timeout");
    check_eq("rand_pixcnt", pixel_count, sent % FP);
    check_eq("rand_frame_done", fd_cnt, sent / FP);
    check_eq("rand_scoreboard_empty", exp_q.size(), 0);

    // Reset in the middle of a pixel.
    clear_logs();
    push_pixel(16'hC0DE);
    wait_bits(8, "rst_mid_bits_timeout");
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("rst_mid_cs_n", bus.tft_cs_n, 1);
    check_eq("rst_mid_sclk", bus.tft_sclk, 0);
    check_eq("rst_mid_pixcnt", pixel_count, 0);
    check_eq("rst_mid_busy", busy, 0);
    exp_q.delete();
    sent = 0;
    repeat (2) @(negedge clk);
    #1;
    reset_n = 1'b1;
    clear_logs();
    push_pixel(16'h5A3C);
    wait_idle("post_rst_timeout");
    sent++;
    check_eq("post_rst_rises", rise_times.size(), 16);
    check_eq("post_rst_word", last_word, 16'h5A3C);
    check_eq("post_rst_pixcnt", pixel_count, 1);
    check_eq("post_rst_frame_done", fd_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1);
  end

endmodule
